combo_lock_ctrl: RTL and testbench
==================================

Name: combo_lock_ctrl

Overview:
- Sequencing controller for the combination lock; consumes the one-cycle pulses produced by the per-button debouncers.
- Checks an entered digit sequence against a stored code and drives unlock, failure and lockout indications.
- Applies timed open, fail-display and lockout intervals, all counted in Clock cycles.
- Sits between the debouncer bank and the LED/display outputs.

Parameters:
- CODE_LEN, 4, number of digits in the code (1..7).
- CODE, 8'b11_10_01_00, stored code as 2-bit digits; digit k occupies bits [2k+1:2k]; digit 0 is entered first.
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..7).
- OPEN_CYCLES, 300000000, cycles Unlocked stays high before auto-relock.
- FAIL_CYCLES, 100000000, cycles the Fail indication stays high.
- LOCKOUT_CYCLES, 500000000, cycles of lockout.

Ports:
- Clock  in  1  system clock.
- Reset_n  in  1  reset.
- Digit_Pulse  in  4  one-cycle pulses from the digit debouncers; bit i means digit value i.
- Enter_Pulse  in  1  one-cycle pulse: submit the entered sequence.
- Lock_Pulse  in  1  one-cycle pulse: relock immediately while open.
- Unlocked  out  1  high in OPEN.
- Fail  out  1  high in FAIL.
- Locked_Out  out  1  high in LOCKOUT.
- Entry_Count  out  3  digits accepted in the current attempt; saturates at CODE_LEN.
- Fail_Count  out  3  consecutive failed attempts.

Behaviour:
- Reset: Reset_n is asynchronous and active-low; Clock is the only clock.
- Reset state: IDLE. All outputs 0. Internal mismatch flag and 32-bit timer cleared.
- Reset mid-operation returns to IDLE immediately, from any state.

State IDLE (accepting entry):
- Digit event: exactly one bit of Digit_Pulse set and Enter_Pulse low.
- On a digit event, compare against CODE digit[Entry_Count].
  - If the digit differs, or Entry_Count is already CODE_LEN, set the mismatch flag.
  - Entry_Count increments, saturating at CODE_LEN.
- More than one Digit_Pulse bit set in one cycle: counts as one digit and sets the mismatch flag.
- Enter_Pulse with any Digit_Pulse in the same cycle: Enter wins and the digit is discarded.
- On Enter_Pulse:
  - If Entry_Count==CODE_LEN and mismatch==0: go to OPEN and clear Fail_Count.
  - Otherwise: increment Fail_Count, then go to LOCKOUT if the new Fail_Count==MAX_FAILS, else go to FAIL.
  - In all cases clear Entry_Count and the mismatch flag, and load the timer.
- Enter_Pulse with Entry_Count==0 is a failed attempt.
- Lock_Pulse is ignored in IDLE.

State OPEN:
- Unlocked=1.
- Return to IDLE after OPEN_CYCLES cycles, or on the cycle after Lock_Pulse, whichever comes first.
- Digit_Pulse and Enter_Pulse are ignored.

State FAIL:
- Fail=1 for FAIL_CYCLES cycles, then IDLE.
- All inputs ignored.

State LOCKOUT:
- Locked_Out=1 for LOCKOUT_CYCLES cycles, then IDLE with Fail_Count cleared.
- All inputs ignored.

Timing:
- Outputs are registered.
- An input pulse sampled at edge N changes outputs after edge N, so they are visible from cycle N+1.
- Timer is loaded with duration-1 on state entry and decrements each cycle; the state exits on the edge where the timer is 0.
- Timed states therefore last exactly their parameter count of cycles.
- Timer does not wrap.

Test Plan (CODE_LEN=4, CODE digits 0,1,2,3, MAX_FAILS=3, OPEN_CYCLES=10, FAIL_CYCLES=5, LOCKOUT_CYCLES=20):
- Correct entry: pulse digits 0,1,2,3 then Enter -> Entry_Count goes 1..4; Unlocked=1 for exactly 10 cycles; Fail_Count=0; then IDLE.
- Early relock: correct code, then Lock_Pulse on the 3rd open cycle -> Unlocked=0 from the next cycle.
- Wrong digit: pulse 0,1,3,3 then Enter -> Fail=1 for 5 cycles; Fail_Count=1; Unlocked stays 0.
- Length errors: 5 digits (0,1,2,3,0) then Enter -> fail. 3 digits (0,1,2) then Enter -> fail. Enter alone -> fail. Third consecutive failure -> Locked_Out=1 for 20 cycles, digits ignored during it, Fail_Count=0 afterwards.
- Simultaneous events: Digit_Pulse=4'b0011 counts as a mismatch; Enter together with digit 3 as the 4th entry -> that digit is discarded and the attempt fails with Entry_Count=3.
- Reset: assert Reset_n=0 asynchronously mid-OPEN and mid-LOCKOUT -> all outputs 0 immediately; a correct code afterwards unlocks.

Source files
------------

// File: rtl/combo_lock_ctrl_if.sv
// Button-pulse inputs and status outputs of the combination lock sequencer.
interface combo_lock_ctrl_if;
   logic [3:0] digit_pulse;
   logic       enter_pulse;
   logic       lock_pulse;
   logic       unlocked;
   logic       fail;
   logic       locked_out;
   logic [2:0] entry_count;
   logic [2:0] fail_count;

   modport master (
      output digit_pulse, enter_pulse, lock_pulse,
      input  unlocked, fail, locked_out, entry_count, fail_count
   );

   modport slave (
      input  digit_pulse, enter_pulse, lock_pulse,
      output unlocked, fail, locked_out, entry_count, fail_count
   );
endinterface

// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: checks a digit sequence, then times open/fail/lockout intervals.
// All outputs registered; a pulse sampled at edge N is visible from cycle N+1; no backpressure.
module combo_lock_ctrl #(
   parameter int unsigned              CODE_LEN       = 4,
   parameter logic [2*CODE_LEN-1:0]    CODE           = 8'b11_10_01_00,
   parameter int unsigned              MAX_FAILS      = 3,
   parameter int unsigned              OPEN_CYCLES    = 300000000,
   parameter int unsigned              FAIL_CYCLES    = 100000000,
   parameter int unsigned              LOCKOUT_CYCLES = 500000000
) (
   input  logic               clk,
   input  logic               rst_n,
   combo_lock_ctrl_if.slave   lock_if
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_OPEN    = 2'd1;
   localparam logic [1:0] S_FAIL    = 2'd2;
   localparam logic [1:0] S_LOCKOUT = 2'd3;

   localparam logic [2:0]  LEN3      = 3'(CODE_LEN);
   localparam logic [2:0]  MAX3      = 3'(MAX_FAILS);
   localparam logic [31:0] T_OPEN    = 32'(OPEN_CYCLES - 1);
   localparam logic [31:0] T_FAIL    = 32'(FAIL_CYCLES - 1);
   localparam logic [31:0] T_LOCKOUT = 32'(LOCKOUT_CYCLES - 1);

   logic [1:0]  state, state_nxt;
   logic [31:0] timer, timer_nxt;
   logic [2:0]  entry_count, entry_count_nxt;
   logic [2:0]  fail_count, fail_count_nxt;
   logic [2:0]  fail_inc;
   logic        mismatch, mismatch_nxt;
   logic        unlocked_q, fail_q, locked_out_q;

   logic        any_digit;
   logic        multi_digit;
   logic [1:0]  digit_val;
   logic [1:0]  exp_digit;

   assign any_digit   = |lock_if.digit_pulse;
   assign multi_digit = any_digit && !$onehot(lock_if.digit_pulse);

   always_comb begin
      digit_val = 2'd0;
      case (lock_if.digit_pulse)
         4'b0010: digit_val = 2'd1;
         4'b0100: digit_val = 2'd2;
         4'b1000: digit_val = 2'd3;
         default: digit_val = 2'd0;
      endcase
   end

   // Out-of-range positions leave exp_digit at 0; those entries mismatch via saturation anyway.
   always_comb begin
      exp_digit = 2'd0;
      for (int k = 0; k < CODE_LEN; k++) begin
         if (entry_count == 3'(k)) exp_digit = CODE[2*k +: 2];
      end
   end

   always_comb begin
      state_nxt       = state;
      timer_nxt       = timer;
      entry_count_nxt = entry_count;
      fail_count_nxt  = fail_count;
      mismatch_nxt    = mismatch;
      fail_inc        = fail_count + 3'd1;
      case (state)
         S_IDLE: begin
            if (lock_if.enter_pulse) begin
               entry_count_nxt = 3'd0;
               mismatch_nxt    = 1'b0;
               if (entry_count == LEN3 && !mismatch) begin
                  state_nxt      = S_OPEN;
                  timer_nxt      = T_OPEN;
                  fail_count_nxt = 3'd0;
               end else begin
                  fail_count_nxt = fail_inc;
                  if (fail_inc == MAX3) begin
                     state_nxt = S_LOCKOUT;
                     timer_nxt = T_LOCKOUT;
                  end else begin
                     state_nxt = S_FAIL;
                     timer_nxt = T_FAIL;
                  end
               end
            end else if (any_digit) begin
               if (entry_count != LEN3) entry_count_nxt = entry_count + 3'd1;
               if (multi_digit || entry_count == LEN3 || digit_val != exp_digit)
                  mismatch_nxt = 1'b1;
            end
         end
         S_OPEN: begin
            if (lock_if.lock_pulse || timer == 32'd0) state_nxt = S_IDLE;
            else                                      timer_nxt = timer - 32'd1;
         end
         S_FAIL: begin
            if (timer == 32'd0) state_nxt = S_IDLE;
            else                timer_nxt = timer - 32'd1;
         end
         S_LOCKOUT: begin
            if (timer == 32'd0) begin
               state_nxt      = S_IDLE;
               fail_count_nxt = 3'd0;
            end else begin
               timer_nxt = timer - 32'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         timer        <= 32'd0;
         entry_count  <= 3'd0;
         fail_count   <= 3'd0;
         mismatch     <= 1'b0;
         unlocked_q   <= 1'b0;
         fail_q       <= 1'b0;
         locked_out_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         entry_count  <= entry_count_nxt;
         fail_count   <= fail_count_nxt;
         mismatch     <= mismatch_nxt;
         unlocked_q   <= (state_nxt == S_OPEN);
         fail_q       <= (state_nxt == S_FAIL);
         locked_out_q <= (state_nxt == S_LOCKOUT);
      end
   end

   assign lock_if.unlocked    = unlocked_q;
   assign lock_if.fail        = fail_q;
   assign lock_if.locked_out  = locked_out_q;
   assign lock_if.entry_count = entry_count;
   assign lock_if.fail_count  = fail_count;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed vector bench for combo_lock_ctrl with short timer parameters.
module tb_combo_lock_ctrl;

   logic clk;
   logic rst_n;

   combo_lock_ctrl_if lock_if ();

   combo_lock_ctrl #(
      .CODE_LEN       (4),
      .CODE           (8'b11_10_01_00),
      .MAX_FAILS      (3),
      .OPEN_CYCLES    (10),
      .FAIL_CYCLES    (5),
      .LOCKOUT_CYCLES (20)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .lock_if (lock_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] dig;
      logic       ent;
      logic       lck;
      int         n;
      logic       unl;
      logic       fl;
      logic       lo;
      logic [2:0] ec;
      logic [2:0] fc;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(logic [3:0] dig, logic ent, logic lck, int n,
                               logic unl, logic fl, logic lo, logic [2:0] ec, logic [2:0] fc);
      vec_t v;
      v.dig = dig; v.ent = ent; v.lck = lck; v.n = n;
      v.unl = unl; v.fl = fl; v.lo = lo; v.ec = ec; v.fc = fc;
      return v;
   endfunction

   task automatic check(string name, int idx, logic unl, logic fl, logic lo,
                        logic [2:0] ec, logic [2:0] fc);
      logic [8:0] got;
      logic [8:0] exp;
      got = {lock_if.unlocked, lock_if.fail, lock_if.locked_out,
             lock_if.entry_count, lock_if.fail_count};
      exp = {unl, fl, lo, ec, fc};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s #%0d: got unl/fail/lo/ec/fc=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                  name, idx, got[8], got[7], got[6], got[5:3], got[2:0],
                  exp[8], exp[7], exp[6], exp[5:3], exp[2:0]);
      end
   endtask

   // Pulse the inputs for one cycle, then idle; outputs are checked #1 after every edge.
   task automatic apply(string name, int idx, vec_t v);
      for (int c = 0; c < v.n; c++) begin
         lock_if.digit_pulse = (c == 0) ? v.dig : 4'b0000;
         lock_if.enter_pulse = (c == 0) ? v.ent : 1'b0;
         lock_if.lock_pulse  = (c == 0) ? v.lck : 1'b0;
         @(posedge clk);
         #1;
         check(name, idx * 100 + c, v.unl, v.fl, v.lo, v.ec, v.fc);
      end
      lock_if.digit_pulse = 4'b0000;
      lock_if.enter_pulse = 1'b0;
      lock_if.lock_pulse  = 1'b0;
   endtask

   task automatic enter_code(string name, logic [2:0] fc_before);
      apply(name, 0, mk(4'b0001, 0, 0, 1, 0, 0, 0, 3'd1, fc_before));
      apply(name, 1, mk(4'b0010, 0, 0, 1, 0, 0, 0, 3'd2, fc_before));
      apply(name, 2, mk(4'b0100, 0, 0, 1, 0, 0, 0, 3'd3, fc_before));
      apply(name, 3, mk(4'b1000, 0, 0, 1, 0, 0, 0, 3'd4, fc_before));
   endtask

   initial begin
      rst_n               = 1'b0;
      lock_if.digit_pulse = 4'b0000;
      lock_if.enter_pulse = 1'b0;
      lock_if.lock_pulse  = 1'b0;

      // correct code; digit/enter ignored while open; open lasts 10 cycles
      tbl.push_back(mk(4'b0001, 0, 0, 1, 0, 0, 0, 3'd1, 3'd0));
      tbl.push_back(mk(4'b0010, 0, 0, 1, 0, 0, 0, 3'd2, 3'd0));
      tbl.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 0, 3'd3, 3'd0));
      tbl.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0, 3'd4, 3'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 3, 1, 0, 0, 3'd0, 3'd0));
      tbl.push_back(mk(4'b0001, 0, 0, 1, 1, 0, 0, 3'd0, 3'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 1, 1, 0, 0, 3'd0, 3'd0));
      tbl.push_back(mk(4'b0000, 0, 0, 5, 1, 0, 0, 3'd0, 3'd0));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0));
      // lock pulse in idle does nothing
      tbl.push_back(mk(4'b0000, 0, 1, 1, 0, 0, 0, 3'd0, 3'd0));
      // wrong digit 0,1,3,3
      tbl.push_back(mk(4'b0001, 0, 0, 1, 0, 0, 0, 3'd1, 3'd0));
      tbl.push_back(mk(4'b0010, 0, 0, 1, 0, 0, 0, 3'd2, 3'd0));
      tbl.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0, 3'd3, 3'd0));
      tbl.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0, 3'd4, 3'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 5, 0, 1, 0, 3'd0, 3'd1));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd1));
      // correct code clears the fail count; lock pulse on 3rd open cycle
      tbl.push_back(mk(4'b0001, 0, 0, 1, 0, 0, 0, 3'd1, 3'd1));
      tbl.push_back(mk(4'b0010, 0, 0, 1, 0, 0, 0, 3'd2, 3'd1));
      tbl.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 0, 3'd3, 3'd1));
      tbl.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0, 3'd4, 3'd1));
      tbl.push_back(mk(4'b0000, 1, 0, 3, 1, 0, 0, 3'd0, 3'd0));
      tbl.push_back(mk(4'b0000, 0, 1, 1, 0, 0, 0, 3'd0, 3'd0));
      // five digits: count saturates at 4, attempt fails
      tbl.push_back(mk(4'b0001, 0, 0, 1, 0, 0, 0, 3'd1, 3'd0));
      tbl.push_back(mk(4'b0010, 0, 0, 1, 0, 0, 0, 3'd2, 3'd0));
      tbl.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 0, 3'd3, 3'd0));
      tbl.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0, 3'd4, 3'd0));
      tbl.push_back(mk(4'b0001, 0, 0, 1, 0, 0, 0, 3'd4, 3'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 5, 0, 1, 0, 3'd0, 3'd1));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd1));
      // enter alone
      tbl.push_back(mk(4'b0000, 1, 0, 5, 0, 1, 0, 3'd0, 3'd2));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd2));
      // three digits -> third failure -> 20-cycle lockout ignoring digits
      tbl.push_back(mk(4'b0001, 0, 0, 1, 0, 0, 0, 3'd1, 3'd2));
      tbl.push_back(mk(4'b0010, 0, 0, 1, 0, 0, 0, 3'd2, 3'd2));
      tbl.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 0, 3'd3, 3'd2));
      tbl.push_back(mk(4'b0000, 1, 0, 5, 0, 0, 1, 3'd0, 3'd3));
      tbl.push_back(mk(4'b0001, 0, 0, 1, 0, 0, 1, 3'd0, 3'd3));
      tbl.push_back(mk(4'b0000, 1, 0, 1, 0, 0, 1, 3'd0, 3'd3));
      tbl.push_back(mk(4'b0000, 0, 0, 13, 0, 0, 1, 3'd0, 3'd3));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0));
      // two digit bits at once count as one mismatching digit
      tbl.push_back(mk(4'b0011, 0, 0, 1, 0, 0, 0, 3'd1, 3'd0));
      tbl.push_back(mk(4'b0010, 0, 0, 1, 0, 0, 0, 3'd2, 3'd0));
      tbl.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 0, 3'd3, 3'd0));
      tbl.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0, 3'd4, 3'd0));
      tbl.push_back(mk(4'b0000, 1, 0, 5, 0, 1, 0, 3'd0, 3'd1));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd1));
      // enter together with the 4th digit: digit discarded, attempt fails
      tbl.push_back(mk(4'b0001, 0, 0, 1, 0, 0, 0, 3'd1, 3'd1));
      tbl.push_back(mk(4'b0010, 0, 0, 1, 0, 0, 0, 3'd2, 3'd1));
      tbl.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 0, 3'd3, 3'd1));
      tbl.push_back(mk(4'b1000, 1, 0, 5, 0, 1, 0, 3'd0, 3'd2));
      tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd2));

      #3;
      check("reset_state", 0, 0, 0, 0, 3'd0, 3'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply("table", i, tbl[i]);

      // asynchronous reset in the middle of OPEN
      enter_code("pre_open", 3'd2);
      apply("open", 0, mk(4'b0000, 1, 0, 3, 1, 0, 0, 3'd0, 3'd0));
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_in_open", 0, 0, 0, 0, 3'd0, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // asynchronous reset in the middle of LOCKOUT
      apply("fail1", 0, mk(4'b0000, 1, 0, 5, 0, 1, 0, 3'd0, 3'd1));
      apply("fail1", 1, mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd1));
      apply("fail2", 0, mk(4'b0000, 1, 0, 5, 0, 1, 0, 3'd0, 3'd2));
      apply("fail2", 1, mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd2));
      apply("lockout", 0, mk(4'b0000, 1, 0, 3, 0, 0, 1, 3'd0, 3'd3));
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_in_lockout", 0, 0, 0, 0, 3'd0, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // correct code after reset unlocks for the full interval
      enter_code("post_rst", 3'd0);
      apply("post_rst_open", 0, mk(4'b0000, 1, 0, 10, 1, 0, 0, 3'd0, 3'd0));
      apply("post_rst_idle", 0, mk(4'b0000, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
